// File: rtl/hdc_class_trainer.sv
// Hyperdimensional two-class trainer: bundles bipolar message hypervectors into
// ham/spam accumulator banks chunk by chunk and streams out the binarized class vectors.
module hdc_class_trainer #(
    parameter int DIM   = 10000,
    parameter int CHUNK = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CHUNK-1:0] in_data,
    input  logic [1:0]       in_label,
    input  logic             in_last,
    input  logic             clear,
    input  logic             rd_start,
    input  logic             rd_class,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CHUNK-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic [15:0]      msg_count_ham,
    output logic [15:0]      msg_count_spam,
    output logic             err_len,
    output logic [1:0]       dbg_state
);

    localparam int NCHUNK = DIM / CHUNK;
    localparam int PTR_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int WORD_W = CHUNK * CNT_W;
    localparam logic [PTR_W-1:0] LAST    = PTR_W'(NCHUNK - 1);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);
    localparam logic [CNT_W-1:0] SAT_POS = {1'b0, {(CNT_W-1){1'b1}}};
    localparam logic [CNT_W-1:0] SAT_NEG = ~SAT_POS + ONE;

    typedef enum logic [1:0] {IDLE, TRAIN, CLEAR, READ} state_t;

    // Handshakes: a beat moves on in_valid && in_ready, a readout chunk on
    // out_valid && out_ready; the sender holds its payload until that cycle.
    state_t             state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [1:0]         label_q;
    logic [1:0]         label_cur;
    logic               cls_q;
    logic               rd_sel;
    logic               acc;
    logic               tr_we;
    logic               clr_we;
    logic               at_last;
    logic [WORD_W-1:0]  ham_mem  [NCHUNK];
    logic [WORD_W-1:0]  spam_mem [NCHUNK];
    logic [WORD_W-1:0]  tr_word;
    logic [WORD_W-1:0]  upd_word;
    logic [CHUNK-1:0]   rd_bits;
    logic [CNT_W-1:0]   elem;

    assign at_last   = (ptr == LAST);
    assign label_cur = (state == IDLE) ? in_label : label_q;
    // clear and rd_start outrank a beat in IDLE, so the beat is refused rather than dropped
    assign in_ready  = (state == TRAIN) || ((state == IDLE) && !clear && !rd_start);
    assign acc       = in_valid && in_ready;
    assign busy      = (state == CLEAR) || (state == READ);
    assign dbg_state = state;
    assign tr_we     = acc && !label_cur[1] && !reset;
    assign clr_we    = (state == CLEAR) && !reset;
    assign rd_sel    = (state == IDLE) ? rd_class : cls_q;
    assign rd_ptr    = ((state != READ) || at_last) ? '0 : ptr + PTR_ONE;
    assign tr_word   = label_cur[0] ? spam_mem[ptr] : ham_mem[ptr];

    always_comb begin
        upd_word = tr_word;
        rd_bits  = '0;
        elem     = '0;
        for (int j = 0; j < CHUNK; j++) begin
            elem = tr_word[j*CNT_W +: CNT_W];
            if (in_data[j]) begin
                if (elem != SAT_POS) elem = elem + ONE;
            end else begin
                if (elem != SAT_NEG) elem = elem - ONE;
            end
            upd_word[j*CNT_W +: CNT_W] = elem;
            // a zero counter is a tie and reads out as +1
            rd_bits[j] = rd_sel ? !spam_mem[rd_ptr][j*CNT_W + CNT_W - 1]
                                : !ham_mem[rd_ptr][j*CNT_W + CNT_W - 1];
        end
    end

    always_ff @(posedge clk) begin
        if (clr_we) begin
            ham_mem[ptr]  <= '0;
            spam_mem[ptr] <= '0;
        end else if (tr_we) begin
            if (label_cur[0]) spam_mem[ptr] <= upd_word;
            else              ham_mem[ptr]  <= upd_word;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= CLEAR;
            ptr            <= '0;
            label_q        <= '0;
            cls_q          <= 1'b0;
            out_valid      <= 1'b0;
            out_data       <= '0;
            out_last       <= 1'b0;
            msg_count_ham  <= '0;
            msg_count_spam <= '0;
            err_len        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clear) begin
                        state          <= CLEAR;
                        ptr            <= '0;
                        msg_count_ham  <= '0;
                        msg_count_spam <= '0;
                        err_len        <= 1'b0;
                    end else if (rd_start) begin
                        cls_q     <= rd_class;
                        state     <= READ;
                        out_valid <= 1'b1;
                        out_data  <= rd_bits;
                        out_last  <= (rd_ptr == LAST);
                    end
                end
                CLEAR: begin
                    if (at_last) begin
                        ptr   <= '0;
                        state <= IDLE;
                    end else begin
                        ptr <= ptr + PTR_ONE;
                    end
                end
                READ: begin
                    // rd_bits already addresses the following chunk, so the next word loads on the handshake
                    if (out_valid && out_ready) begin
                        if (at_last) begin
                            ptr       <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            ptr      <= ptr + PTR_ONE;
                            out_data <= rd_bits;
                            out_last <= (rd_ptr == LAST);
                        end
                    end
                end
                TRAIN: ;
                default: state <= IDLE;
            endcase

            if (acc) begin
                if (in_last) begin
                    ptr   <= '0;
                    state <= IDLE;
                    if (!at_last) err_len <= 1'b1;
                    if ((label_cur == 2'd0) && (msg_count_ham != 16'hFFFF))
                        msg_count_ham <= msg_count_ham + 16'd1;
                    if ((label_cur == 2'd1) && (msg_count_spam != 16'hFFFF))
                        msg_count_spam <= msg_count_spam + 16'd1;
                end else begin
                    state   <= TRAIN;
                    label_q <= label_cur;
                    if (at_last) begin
                        ptr     <= '0;
                        err_len <= 1'b1;
                    end else begin
                        ptr <= ptr + PTR_ONE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_hdc_class_trainer.sv
// Bench for hdc_class_trainer with counters narrowed to 4 bits so saturation is reachable;
// readout chunks are predicted from an element-level model and checked by a monitor.
module tb_hdc_class_trainer;

    localparam int DIM   = 10000;
    localparam int CHUNK = 16;
    localparam int CNT_W = 4;
    localparam int NCH   = DIM / CHUNK;
    localparam int SAT   = (1 << (CNT_W - 1)) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [CHUNK-1:0] in_data = '0;
    logic [1:0]       in_label = '0;
    logic             in_last = 1'b0;
    logic             clear = 1'b0;
    logic             rd_start = 1'b0;
    logic             rd_class = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [CHUNK-1:0] out_data;
    logic             out_last;
    logic             busy;
    logic [15:0]      msg_count_ham;
    logic [15:0]      msg_count_spam;
    logic             err_len;
    logic [1:0]       dbg_state;

    hdc_class_trainer #(.DIM(DIM), .CHUNK(CHUNK), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_label(in_label), .in_last(in_last),
        .clear(clear), .rd_start(rd_start), .rd_class(rd_class),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .busy(busy), .msg_count_ham(msg_count_ham), .msg_count_spam(msg_count_spam),
        .err_len(err_len), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;

    int              model [2][DIM];
    int              exp_cnt [2];
    logic            exp_err;
    logic [CHUNK:0]  exp_q [$];
    int              n_checks = 0;
    int              n_fail = 0;
    int              n_popped = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic void model_clear();
        for (int c = 0; c < 2; c++)
            for (int e = 0; e < DIM; e++) model[c][e] = 0;
        exp_cnt[0] = 0;
        exp_cnt[1] = 0;
        exp_err = 1'b0;
    endfunction

    function automatic void model_beat(input int lbl, input int c, input logic [CHUNK-1:0] d);
        int v;
        if (lbl > 1) return;
        for (int j = 0; j < CHUNK; j++) begin
            v = model[lbl][c*CHUNK + j] + (d[j] ? 1 : -1);
            if (v > SAT) v = SAT;
            if (v < -SAT) v = -SAT;
            model[lbl][c*CHUNK + j] = v;
        end
    endfunction

    function automatic logic [CHUNK-1:0] exp_chunk(input int cls, input int c);
        logic [CHUNK-1:0] r;
        for (int j = 0; j < CHUNK; j++) r[j] = (model[cls][c*CHUNK + j] >= 0);
        return r;
    endfunction

    task automatic send_beat(input logic [CHUNK-1:0] d, input logic [1:0] lbl, input logic lst);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_label = lbl;
        in_last  = lst;
        while (!in_ready && guard < 4*NCH) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) check("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic send_msg(input int lbl, input int nbeats, input bit rnd, input logic [CHUNK-1:0] cd);
        logic [31:0]      r;
        logic [CHUNK-1:0] d;
        for (int b = 0; b < nbeats; b++) begin
            r = $urandom();
            d = rnd ? r[CHUNK-1:0] : cd;
            model_beat(lbl, b % NCH, d);
            send_beat(d, 2'(lbl), b == nbeats - 1);
        end
        if (lbl < 2 && exp_cnt[lbl] < 65535) exp_cnt[lbl]++;
        if (nbeats != NCH) exp_err = 1'b1;
    endtask

    task automatic check_status(input string tag);
        check({tag, "_count_ham"}, {16'd0, msg_count_ham}, exp_cnt[0]);
        check({tag, "_count_spam"}, {16'd0, msg_count_spam}, exp_cnt[1]);
        check({tag, "_err_len"}, {31'd0, err_len}, {31'd0, exp_err});
        check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    endtask

    task automatic do_read(input int cls, input int stall_chunk, input int stall_len, input bit rnd);
        int got;
        int stalled;
        int guard;
        logic [CHUNK-1:0] stall_data;
        stall_data = '0;
        for (int c = 0; c < NCH; c++) exp_q.push_back({c == NCH - 1, exp_chunk(cls, c)});
        if (stall_chunk >= 0) stall_data = exp_chunk(cls, stall_chunk);
        rd_class = cls[0];
        rd_start = 1'b1;
        @(negedge clk);
        rd_start = 1'b0;
        got = 0;
        stalled = 0;
        guard = 0;
        while (got < NCH && guard < 8*NCH) begin
            if (got == stall_chunk && stalled < stall_len) begin
                out_ready = 1'b0;
                stalled++;
            end else if (rnd) begin
                out_ready = ($urandom_range(0, 3) != 0);
            end else begin
                out_ready = 1'b1;
            end
            #1;
            if (!out_ready && got == stall_chunk) begin
                check("stall_out_valid", {31'd0, out_valid}, 32'd1);
                check("stall_out_data", {16'd0, out_data}, {16'd0, stall_data});
            end
            if (out_valid && out_ready) got++;
            @(negedge clk);
            guard++;
        end
        out_ready = 1'b0;
        check("read_chunks_delivered", got, NCH);
        check("read_back_idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_clear();
        int n;
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n = 0;
        while (busy && n < 4*NCH) begin
            n++;
            @(negedge clk);
        end
        check("clear_busy_cycles", n, NCH);
        model_clear();
    endtask

    task automatic apply_reset();
        int n;
        logic ready_seen;
        in_valid  = 1'b0;
        clear     = 1'b0;
        rd_start  = 1'b0;
        out_ready = 1'b0;
        reset     = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        n = 0;
        ready_seen = 1'b0;
        while (busy && n < 4*NCH) begin
            if (in_ready) ready_seen = 1'b1;
            n++;
            @(negedge clk);
        end
        check("reset_busy_cycles", n, NCH);
        check("reset_in_ready_low", {31'd0, ready_seen}, 32'd0);
        model_clear();
    endtask

    // monitor: every accepted readout chunk is matched against the head of exp_q
    initial begin
        logic [CHUNK:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (out_valid === 1'b1 && out_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL read_unexpected: got %0h, expected no output", {out_last, out_data});
                end else begin
                    e = exp_q.pop_front();
                    check($sformatf("read_chunk_%0d", n_popped % NCH), {15'd0, out_last, out_data}, {15'd0, e});
                    n_popped++;
                end
            end
        end
    end

    initial begin
        #(900000 * 10);
        $display("FAIL watchdog: got timeout, expected test completion");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] r;
        apply_reset();
        check_status("after_reset");
        do_read(0, -1, 0, 1'b0);

        send_msg(0, NCH, 1'b0, 16'h0000);
        check_status("one_ham");
        do_read(0, -1, 0, 1'b0);
        do_read(1, -1, 0, 1'b0);

        send_msg(1, NCH, 1'b0, 16'hAAAA);
        send_msg(1, NCH, 1'b0, 16'hAAAA);
        send_msg(1, NCH, 1'b0, 16'h5555);
        check_status("three_spam");
        do_read(1, -1, 0, 1'b0);
        do_read(1, 10, 5, 1'b0);

        send_msg(0, 100, 1'b1, '0);
        check_status("short_msg");
        send_msg(1, NCH, 1'b1, '0);
        do_read(1, -1, 0, 1'b1);
        do_read(0, -1, 0, 1'b1);
        check_status("after_short");

        do_clear();
        check_status("after_clear");
        send_msg(0, NCH + 7, 1'b1, '0);
        send_msg(2, NCH, 1'b1, '0);
        send_msg(3, NCH, 1'b1, '0);
        check_status("wrap_discard");
        do_read(0, -1, 0, 1'b1);
        do_read(1, -1, 0, 1'b0);

        do_clear();
        for (int i = 0; i < 9; i++) send_msg(0, NCH, 1'b0, 16'hFFFF);
        for (int i = 0; i < 7; i++) send_msg(0, NCH, 1'b0, 16'h0000);
        do_read(0, -1, 0, 1'b0);
        send_msg(0, NCH, 1'b0, 16'h0000);
        check_status("saturation");
        do_read(0, -1, 0, 1'b0);

        for (int i = 0; i < 3; i++) send_msg(int'($urandom_range(0, 3)), NCH, 1'b1, '0);
        check_status("random_msgs");
        do_read(0, -1, 0, 1'b1);
        do_read(1, -1, 0, 1'b1);

        for (int b = 0; b < 50; b++) begin
            r = $urandom();
            send_beat(r[CHUNK-1:0], 2'd0, 1'b0);
        end
        apply_reset();
        check_status("mid_msg_reset");
        do_read(0, -1, 0, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
